if_stage: RTL and testbench

Instruction-fetch stage of the 5-stage MIPS pipeline. It sits directly upstream of the decode stage.
- Holds the fetch PC and issues one word request at a time on a req/addr_ok/data_ok instruction-memory interface.
- Presents PC, PC+4 and the instruction word to decode using the valid/allowin handshake.
- Applies decode-resolved branch/jump redirects after the architectural delay slot.

---
 rtl/if_stage.sv | 128 ++++++++++++
 tb/tb_if_stage.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage: one outstanding fetch on req/addr_ok/data_ok, valid/allowin to decode,
// delay-slot-aware redirects. Define IF_ADDR_ERR_EN to trap misaligned fetches via IF_AdEL.
module if_stage #(
   parameter logic [31:0] RESET_PC = 32'hBFC00000
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        ID_allowin,
   input  logic        ID_PCSrc,
   input  logic [31:0] ID_PCBranch,
   output logic        IF_to_ID_valid,
   output logic [31:0] PC,
   output logic [31:0] next_PC,
   output logic [31:0] ins_reg,
`ifdef IF_ADDR_ERR_EN
   output logic        IF_AdEL,
`endif
   output logic        inst_req,
   output logic [31:0] inst_addr,
   input  logic        inst_addr_ok,
   input  logic        inst_data_ok,
   input  logic [31:0] inst_rdata
);
   localparam int unsigned AW = 32;

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_t;

   state_t        state;
   logic [AW-1:0] fetch_pc;
   logic [AW-1:0] req_pc;
   logic [AW-1:0] br_target;
   logic          br_pending;
   logic          redirect;
   logic [AW-1:0] hold_next_pc;
   logic          fetch_ok;
   logic          hold_next_ok;

   assign redirect = ID_PCSrc && ID_allowin;

   // Fetch address used when the held instruction leaves; a same-cycle redirect wins over a deferred one.
   assign hold_next_pc = redirect ? ID_PCBranch : (br_pending ? br_target : fetch_pc);

`ifdef IF_ADDR_ERR_EN
   assign fetch_ok     = (fetch_pc[1:0] == 2'b00);
   assign hold_next_ok = (hold_next_pc[1:0] == 2'b00);
   assign inst_addr    = fetch_pc;
`else
   assign fetch_ok     = 1'b1;
   assign hold_next_ok = 1'b1;
   assign inst_addr    = {fetch_pc[AW-1:2], 2'b00};
`endif

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state          <= S_IDLE;
         fetch_pc       <= RESET_PC;
         req_pc         <= '0;
         br_pending     <= 1'b0;
         br_target      <= '0;
         IF_to_ID_valid <= 1'b0;
         PC             <= '0;
         next_PC        <= '0;
         ins_reg        <= '0;
         inst_req       <= 1'b0;
`ifdef IF_ADDR_ERR_EN
         IF_AdEL        <= 1'b0;
`endif
      end else begin
         // Branch leaves decode while its delay slot is still being fetched: remember the target.
         if (redirect && (state == S_REQ || state == S_WAIT)) begin
            br_pending <= 1'b1;
            br_target  <= ID_PCBranch;
         end

         case (state)
            S_IDLE: begin
               state    <= S_REQ;
               inst_req <= fetch_ok;
            end

            S_REQ: begin
`ifdef IF_ADDR_ERR_EN
               if (!fetch_ok) begin
                  state          <= S_HOLD;
                  IF_to_ID_valid <= 1'b1;
                  PC             <= fetch_pc;
                  next_PC        <= fetch_pc + AW'(4);
                  ins_reg        <= '0;
                  IF_AdEL        <= 1'b1;
               end else
`endif
               if (inst_addr_ok) begin
                  state    <= S_WAIT;
                  inst_req <= 1'b0;
                  req_pc   <= fetch_pc;
               end
            end

            S_WAIT: begin
               if (inst_data_ok) begin
                  state          <= S_HOLD;
                  IF_to_ID_valid <= 1'b1;
                  ins_reg        <= inst_rdata;
                  PC             <= req_pc;
                  next_PC        <= req_pc + AW'(4);
                  fetch_pc       <= req_pc + AW'(4);
               end
            end

            S_HOLD: begin
               if (ID_allowin) begin
                  state          <= S_REQ;
                  IF_to_ID_valid <= 1'b0;
                  fetch_pc       <= hold_next_pc;
                  br_pending     <= 1'b0;
                  inst_req       <= hold_next_ok;
`ifdef IF_ADDR_ERR_EN
                  IF_AdEL        <= 1'b0;
`endif
               end
            end

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: fixed-latency memory responder records accepted requests,
// scenario tasks push expected fetch addresses and compare deliveries to decode.
module tb_if_stage;
   logic        clk = 1'b0;
   logic        resetn;
   logic        ID_allowin;
   logic        ID_PCSrc;
   logic [31:0] ID_PCBranch;
   logic        IF_to_ID_valid;
   logic [31:0] PC;
   logic [31:0] next_PC;
   logic [31:0] ins_reg;
`ifdef IF_ADDR_ERR_EN
   logic        IF_AdEL;
`endif
   logic        inst_req;
   logic [31:0] inst_addr;
   logic        inst_addr_ok;
   logic        inst_data_ok;
   logic [31:0] inst_rdata;

   int          vectors = 0;
   int          miscompares = 0;
   logic        mem_en;
   int          data_cnt;
   logic [31:0] pend_addr;
   logic [31:0] seen_q[$];
   logic [31:0] exp_q[$];

   if_stage #(.RESET_PC(32'hBFC00000)) dut (
      .clk(clk),
      .resetn(resetn),
      .ID_allowin(ID_allowin),
      .ID_PCSrc(ID_PCSrc),
      .ID_PCBranch(ID_PCBranch),
      .IF_to_ID_valid(IF_to_ID_valid),
      .PC(PC),
      .next_PC(next_PC),
      .ins_reg(ins_reg),
`ifdef IF_ADDR_ERR_EN
      .IF_AdEL(IF_AdEL),
`endif
      .inst_req(inst_req),
      .inst_addr(inst_addr),
      .inst_addr_ok(inst_addr_ok),
      .inst_data_ok(inst_data_ok),
      .inst_rdata(inst_rdata)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'hBFC00000) return 32'h24010001;
      return a ^ 32'h5A5A0000;
   endfunction

   // Memory: addr_ok in the same cycle as req, data_ok one cycle later.
   always @(negedge clk) begin
      inst_addr_ok = 1'b0;
      inst_data_ok = 1'b0;
      if (!resetn) begin
         data_cnt   = 0;
         inst_rdata = '0;
      end else if (data_cnt > 0) begin
         data_cnt = data_cnt - 1;
         if (data_cnt == 0) begin
            inst_data_ok = 1'b1;
            inst_rdata   = mem_word(pend_addr);
         end
      end else if (inst_req && mem_en) begin
         inst_addr_ok = 1'b1;
         pend_addr    = inst_addr;
         seen_q.push_back(inst_addr);
         data_cnt     = 1;
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_valid(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (IF_to_ID_valid === 1'b1) begin
            ok = 1'b1;
            break;
         end
         cyc();
      end
   endtask

   task automatic release_insn(input logic br, input logic [31:0] tgt);
      ID_allowin  = 1'b1;
      ID_PCSrc    = br;
      ID_PCBranch = tgt;
      cyc();
      ID_allowin  = 1'b0;
      ID_PCSrc    = 1'b0;
   endtask

   task automatic test_reset();
      repeat (3) cyc();
      vectors++; if (IF_to_ID_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", IF_to_ID_valid); end
      vectors++; if (PC !== 32'h0) begin miscompares++; $display("FAIL reset_pc got %h want 0", PC); end
      vectors++; if (next_PC !== 32'h0) begin miscompares++; $display("FAIL reset_next_pc got %h want 0", next_PC); end
      vectors++; if (ins_reg !== 32'h0) begin miscompares++; $display("FAIL reset_ins got %h want 0", ins_reg); end
      vectors++; if (inst_req !== 1'b0) begin miscompares++; $display("FAIL reset_req got %b want 0", inst_req); end
   endtask

   task automatic test_first_fetch();
      bit ok;
      logic [31:0] got, want;
      exp_q.push_back(32'hBFC00000);
      resetn = 1'b1;
      cyc();
      vectors++; if (inst_req !== 1'b1 || inst_addr !== 32'hBFC00000) begin miscompares++; $display("FAIL first_req got req=%b addr=%h want req=1 addr=bfc00000", inst_req, inst_addr); end
      wait_valid(ok);
      vectors++; if (!ok) begin miscompares++; $display("FAIL first_valid got 0 want 1 (timeout)"); end
      got = 'x; if (seen_q.size() != 0) got = seen_q.pop_front();
      want = exp_q.pop_front();
      vectors++; if (got !== want) begin miscompares++; $display("FAIL first_req_addr got %h want %h", got, want); end
      vectors++; if (PC !== 32'hBFC00000) begin miscompares++; $display("FAIL first_pc got %h want bfc00000", PC); end
      vectors++; if (next_PC !== 32'hBFC00004) begin miscompares++; $display("FAIL first_next_pc got %h want bfc00004", next_PC); end
      vectors++; if (ins_reg !== 32'h24010001) begin miscompares++; $display("FAIL first_ins got %h want 24010001", ins_reg); end
   endtask

   task automatic test_hold_stall();
      bit ok;
      logic [31:0] got, want;
      for (int i = 0; i < 3; i++) begin
         cyc();
         vectors++;
         if (IF_to_ID_valid !== 1'b1 || PC !== 32'hBFC00000 || ins_reg !== 32'h24010001 || inst_req !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_hold got valid=%b pc=%h ins=%h req=%b want 1 bfc00000 24010001 0", IF_to_ID_valid, PC, ins_reg, inst_req);
         end
      end
      exp_q.push_back(32'hBFC00004);
      release_insn(1'b0, 32'h0);
      vectors++; if (inst_req !== 1'b1 || inst_addr !== 32'hBFC00004 || IF_to_ID_valid !== 1'b0) begin miscompares++; $display("FAIL stall_next_req got req=%b addr=%h valid=%b want 1 bfc00004 0", inst_req, inst_addr, IF_to_ID_valid); end
      wait_valid(ok);
      vectors++; if (!ok) begin miscompares++; $display("FAIL stall_valid got 0 want 1 (timeout)"); end
      got = 'x; if (seen_q.size() != 0) got = seen_q.pop_front();
      want = exp_q.pop_front();
      vectors++; if (got !== want) begin miscompares++; $display("FAIL stall_req_addr got %h want %h", got, want); end
      vectors++; if (PC !== 32'hBFC00004 || ins_reg !== mem_word(32'hBFC00004)) begin miscompares++; $display("FAIL stall_deliver got pc=%h ins=%h want bfc00004 %h", PC, ins_reg, mem_word(32'hBFC00004)); end
   endtask

   task automatic test_branch_in_hold();
      bit ok;
      logic [31:0] got, want;
      exp_q.push_back(32'hBFC00008);
      release_insn(1'b0, 32'h0);
      wait_valid(ok);
      got = 'x; if (seen_q.size() != 0) got = seen_q.pop_front();
      want = exp_q.pop_front();
      vectors++; if (!ok || got !== want || PC !== 32'hBFC00008) begin miscompares++; $display("FAIL hold_slot got ok=%b req=%h pc=%h want 1 %h bfc00008", ok, got, PC, want); end
      exp_q.push_back(32'hBFC00100);
      release_insn(1'b1, 32'hBFC00100);
      vectors++; if (inst_req !== 1'b1 || inst_addr !== 32'hBFC00100) begin miscompares++; $display("FAIL hold_redirect_addr got req=%b addr=%h want 1 bfc00100", inst_req, inst_addr); end
      wait_valid(ok);
      got = 'x; if (seen_q.size() != 0) got = seen_q.pop_front();
      want = exp_q.pop_front();
      vectors++; if (!ok || got !== want) begin miscompares++; $display("FAIL hold_redirect_req got ok=%b req=%h want 1 %h", ok, got, want); end
      vectors++; if (PC !== 32'hBFC00100 || next_PC !== 32'hBFC00104) begin miscompares++; $display("FAIL hold_redirect_pc got %h/%h want bfc00100/bfc00104", PC, next_PC); end
   endtask

   task automatic test_branch_in_wait();
      bit ok;
      logic [31:0] got, want;
      exp_q.push_back(32'hBFC00104);
      release_insn(1'b0, 32'h0);
      cyc();
      vectors++; if (inst_req !== 1'b0 || IF_to_ID_valid !== 1'b0) begin miscompares++; $display("FAIL wait_state got req=%b valid=%b want 0 0", inst_req, IF_to_ID_valid); end
      release_insn(1'b1, 32'hBFC00200);
      got = 'x; if (seen_q.size() != 0) got = seen_q.pop_front();
      want = exp_q.pop_front();
      vectors++; if (got !== want) begin miscompares++; $display("FAIL wait_slot_req got %h want %h", got, want); end
      vectors++; if (IF_to_ID_valid !== 1'b1 || PC !== 32'hBFC00104) begin miscompares++; $display("FAIL wait_slot_deliver got valid=%b pc=%h want 1 bfc00104", IF_to_ID_valid, PC); end
      exp_q.push_back(32'hBFC00200);
      release_insn(1'b0, 32'h0);
      wait_valid(ok);
      got = 'x; if (seen_q.size() != 0) got = seen_q.pop_front();
      want = exp_q.pop_front();
      vectors++; if (!ok || got !== want || PC !== 32'hBFC00200) begin miscompares++; $display("FAIL wait_target got ok=%b req=%h pc=%h want 1 %h bfc00200", ok, got, PC, want); end
   endtask

   task automatic test_branch_in_req();
      bit ok;
      logic [31:0] got, want;
      mem_en = 1'b0;
      exp_q.push_back(32'hBFC00204);
      release_insn(1'b0, 32'h0);
      for (int i = 0; i < 3; i++) begin
         if (i == 1) release_insn(1'b1, 32'hBFC00300);
         else cyc();
         vectors++;
         if (inst_req !== 1'b1 || inst_addr !== 32'hBFC00204 || IF_to_ID_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL req_stable got req=%b addr=%h valid=%b want 1 bfc00204 0", inst_req, inst_addr, IF_to_ID_valid);
         end
      end
      mem_en = 1'b1;
      wait_valid(ok);
      got = 'x; if (seen_q.size() != 0) got = seen_q.pop_front();
      want = exp_q.pop_front();
      vectors++; if (!ok || got !== want || PC !== 32'hBFC00204) begin miscompares++; $display("FAIL req_slot got ok=%b req=%h pc=%h want 1 %h bfc00204", ok, got, PC, want); end
      exp_q.push_back(32'hBFC00300);
      release_insn(1'b0, 32'h0);
      wait_valid(ok);
      got = 'x; if (seen_q.size() != 0) got = seen_q.pop_front();
      want = exp_q.pop_front();
      vectors++; if (!ok || got !== want || PC !== 32'hBFC00300) begin miscompares++; $display("FAIL req_target got ok=%b req=%h pc=%h want 1 %h bfc00300", ok, got, PC, want); end
   endtask

   task automatic test_pcsrc_no_allowin();
      bit ok;
      logic [31:0] got, want;
      ID_PCSrc    = 1'b1;
      ID_PCBranch = 32'hDEAD0000;
      for (int i = 0; i < 2; i++) begin
         cyc();
         vectors++;
         if (IF_to_ID_valid !== 1'b1 || PC !== 32'hBFC00300 || inst_req !== 1'b0) begin
            miscompares++;
            $display("FAIL nosrc_hold got valid=%b pc=%h req=%b want 1 bfc00300 0", IF_to_ID_valid, PC, inst_req);
         end
      end
      ID_PCSrc = 1'b0;
      exp_q.push_back(32'hBFC00304);
      release_insn(1'b0, 32'h0);
      wait_valid(ok);
      got = 'x; if (seen_q.size() != 0) got = seen_q.pop_front();
      want = exp_q.pop_front();
      vectors++; if (!ok || got !== want || PC !== 32'hBFC00304) begin miscompares++; $display("FAIL nosrc_seq got ok=%b req=%h pc=%h want 1 %h bfc00304", ok, got, PC, want); end
   endtask

   task automatic test_wrap();
      bit ok;
      logic [31:0] got, want;
      exp_q.push_back(32'hFFFFFFFC);
      release_insn(1'b1, 32'hFFFFFFFC);
      wait_valid(ok);
      got = 'x; if (seen_q.size() != 0) got = seen_q.pop_front();
      want = exp_q.pop_front();
      vectors++; if (!ok || got !== want) begin miscompares++; $display("FAIL wrap_req got ok=%b req=%h want 1 %h", ok, got, want); end
      vectors++; if (PC !== 32'hFFFFFFFC || next_PC !== 32'h0 || ins_reg !== mem_word(32'hFFFFFFFC)) begin miscompares++; $display("FAIL wrap_deliver got %h/%h/%h want fffffffc/00000000/%h", PC, next_PC, ins_reg, mem_word(32'hFFFFFFFC)); end
      exp_q.push_back(32'h0);
      release_insn(1'b0, 32'h0);
      wait_valid(ok);
      got = 'x; if (seen_q.size() != 0) got = seen_q.pop_front();
      want = exp_q.pop_front();
      vectors++; if (!ok || got !== want || PC !== 32'h0) begin miscompares++; $display("FAIL wrap_zero got ok=%b req=%h pc=%h want 1 %h 0", ok, got, PC, want); end
   endtask

   task automatic test_misaligned();
      bit ok;
      logic [31:0] got, want;
`ifdef IF_ADDR_ERR_EN
      release_insn(1'b1, 32'hBFC00102);
      vectors++; if (inst_req !== 1'b0) begin miscompares++; $display("FAIL adel_no_req got req=%b want 0", inst_req); end
      wait_valid(ok);
      vectors++; if (!ok || PC !== 32'hBFC00102 || next_PC !== 32'hBFC00106 || ins_reg !== 32'h0) begin miscompares++; $display("FAIL adel_deliver got ok=%b %h/%h/%h want 1 bfc00102/bfc00106/0", ok, PC, next_PC, ins_reg); end
      vectors++; if (IF_AdEL !== 1'b1 || seen_q.size() != 0) begin miscompares++; $display("FAIL adel_flag got adel=%b reqs=%0d want 1 0", IF_AdEL, seen_q.size()); end
      exp_q.push_back(32'hBFC00400);
      release_insn(1'b1, 32'hBFC00400);
      vectors++; if (IF_AdEL !== 1'b0 || inst_req !== 1'b1 || inst_addr !== 32'hBFC00400) begin miscompares++; $display("FAIL adel_clear got adel=%b req=%b addr=%h want 0 1 bfc00400", IF_AdEL, inst_req, inst_addr); end
`else
      exp_q.push_back(32'hBFC00100);
      release_insn(1'b1, 32'hBFC00102);
      vectors++; if (inst_req !== 1'b1 || inst_addr !== 32'hBFC00100) begin miscompares++; $display("FAIL align_addr got req=%b addr=%h want 1 bfc00100", inst_req, inst_addr); end
      wait_valid(ok);
      got = 'x; if (seen_q.size() != 0) got = seen_q.pop_front();
      want = exp_q.pop_front();
      vectors++; if (!ok || got !== want) begin miscompares++; $display("FAIL align_req got ok=%b req=%h want 1 %h", ok, got, want); end
      vectors++; if (PC !== 32'hBFC00102 || ins_reg !== mem_word(32'hBFC00100)) begin miscompares++; $display("FAIL align_deliver got pc=%h ins=%h want bfc00102 %h", PC, ins_reg, mem_word(32'hBFC00100)); end
      exp_q.push_back(32'hBFC00400);
      release_insn(1'b1, 32'hBFC00400);
`endif
      wait_valid(ok);
      got = 'x; if (seen_q.size() != 0) got = seen_q.pop_front();
      want = exp_q.pop_front();
      vectors++; if (!ok || got !== want || PC !== 32'hBFC00400) begin miscompares++; $display("FAIL recover got ok=%b req=%h pc=%h want 1 %h bfc00400", ok, got, PC, want); end
   endtask

   initial begin
      resetn      = 1'b0;
      ID_allowin  = 1'b0;
      ID_PCSrc    = 1'b0;
      ID_PCBranch = 32'h0;
      mem_en      = 1'b1;
      test_reset();
      test_first_fetch();
      test_hold_stall();
      test_branch_in_hold();
      test_branch_in_wait();
      test_branch_in_req();
      test_pcsrc_no_allowin();
      test_wrap();
      test_misaligned();
      repeat (2) cyc();
      vectors++; if (seen_q.size() != 0 || exp_q.size() != 0) begin miscompares++; $display("FAIL sb_drain got seen=%0d exp=%0d want 0 0", seen_q.size(), exp_q.size()); end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
